// File: rtl/irq_timer_if.sv
// Bridge-side register port of the interrupt timer: word select, write strobe, data and IRQ.
interface irq_timer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [3:2]       Addr;
    logic             WE;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] DOUT;
    logic             IRQ;

    // CPU / bridge side drives the register port
    modport master (
        output Addr,
        output WE,
        output DIN,
        input  DOUT,
        input  IRQ
    );

    // Timer side
    modport slave (
        input  Addr,
        input  WE,
        input  DIN,
        output DOUT,
        output IRQ
    );
endinterface

// File: rtl/irq_timer.sv
// Programmable countdown timer feeding HWInt[0]; one-shot and auto-reload modes.
module irq_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    irq_timer_if.slave bus
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] dout_c;
    logic [WIDTH-1:0] ctrl_word_c;

    // State and register file update
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Countdown sequencing, then bus writes override the FSM's choices
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // COUNT of 0 terminates like 1, so PRESET=0 acts as PRESET=1
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (mode_q == MODE_RELOAD) begin
                    flag_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.WE) begin
            case (bus.Addr)
                ADDR_CTRL: begin
                    en_d    = bus.DIN[0];
                    mode_d  = bus.DIN[2:1];
                    im_d    = bus.DIN[3];
                    flag_d  = 1'b0;
                    count_d = count_q;
                    state_d = bus.DIN[0] ? S_LOAD : S_IDLE;
                end
                ADDR_PRESET: begin
                    // Takes effect at the next LOAD; running count untouched
                    preset_d = bus.DIN;
                    flag_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Combinational read mux; reserved word reads zero
    always_comb begin
        ctrl_word_c      = '0;
        ctrl_word_c[0]   = en_q;
        ctrl_word_c[2:1] = mode_q;
        ctrl_word_c[3]   = im_q;
        case (bus.Addr)
            ADDR_CTRL:   dout_c = ctrl_word_c;
            ADDR_PRESET: dout_c = preset_q;
            ADDR_COUNT:  dout_c = count_q;
            default:     dout_c = '0;
        endcase
    end

    assign bus.DOUT = dout_c;
    assign bus.IRQ  = flag_q & im_q;

endmodule
